// File: rtl/vga_mem_pkg.sv
// Shared types and elaboration helpers for the VGA frame memory.
package vga_mem_pkg;

  typedef enum logic {
    IDLE,
    FILL
  } fill_state_t;

  function automatic int lane_count(input int data_width, input int lane_width);
    return data_width / lane_width;
  endfunction

  function automatic bit latency_ok(input int latency);
    return (latency == 1) || (latency == 2);
  endfunction

endpackage

// File: rtl/vga_frame_mem_if.sv
// Bus bundle between the game/draw logic, the VGA scanout and the frame memory.
interface vga_frame_mem_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LANE_WIDTH = 8,
  parameter int ADDR_WIDTH = 13
);
  localparam int NL = DATA_WIDTH / LANE_WIDTH;

  logic                  a_req;
  logic                  a_ready;
  logic [NL-1:0]         a_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic [DATA_WIDTH-1:0] a_rdata;
  logic                  a_rvalid;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_rdata;
  logic                  fill_start;
  logic [ADDR_WIDTH-1:0] fill_base;
  logic [ADDR_WIDTH:0]   fill_len;
  logic [DATA_WIDTH-1:0] fill_value;
  logic                  fill_busy;
  logic                  fill_done;

  modport master (
    output a_req, a_we, a_addr, a_wdata, b_addr,
           fill_start, fill_base, fill_len, fill_value,
    input  a_ready, a_rdata, a_rvalid, b_rdata, fill_busy, fill_done
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata, b_addr,
           fill_start, fill_base, fill_len, fill_value,
    output a_ready, a_rdata, a_rvalid, b_rdata, fill_busy, fill_done
  );

endinterface

// File: rtl/vga_mem_bank.sv
// Storage array: one lane-masked write port, two registered read ports with
// write-first bypass so a read of the word being written sees the merged value.
module vga_mem_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int LANE_WIDTH = 8,
  parameter int ADDR_WIDTH = 13,
  parameter int NL         = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NL-1:0]         we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  a_en,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic [DATA_WIDTH-1:0] b_rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] a_merged;
  logic [DATA_WIDTH-1:0] b_merged;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NL; i++) begin
      if (we[i]) begin
        mem[waddr][i*LANE_WIDTH +: LANE_WIDTH] <= wdata[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  always_comb begin
    a_merged = mem[a_addr];
    b_merged = mem[b_addr];
    for (int i = 0; i < NL; i++) begin
      if (we[i] && (a_addr == waddr)) begin
        a_merged[i*LANE_WIDTH +: LANE_WIDTH] = wdata[i*LANE_WIDTH +: LANE_WIDTH];
      end
      if (we[i] && (b_addr == waddr)) begin
        b_merged[i*LANE_WIDTH +: LANE_WIDTH] = wdata[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      if (a_en) begin
        a_rdata <= a_merged;
      end
      b_rdata <= b_merged;
    end
  end

endmodule

// File: rtl/vga_frame_mem.sv
// Dual-port VGA frame memory with byte-lane writes, handshaked port A,
// free-running scanout port B and a linear fill engine.
module vga_frame_mem
  import vga_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int LANE_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 13,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 0
) (
  input logic             clk,
  input logic             rst,
  vga_frame_mem_if.slave  bus
);

  localparam int NL = lane_count(DATA_WIDTH, LANE_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  if (!latency_ok(READ_LATENCY)) begin : g_bad_latency
    $error("vga_frame_mem: READ_LATENCY must be 1 or 2");
  end
  if ((DATA_WIDTH % LANE_WIDTH) != 0) begin : g_bad_lanes
    $error("vga_frame_mem: DATA_WIDTH must be a multiple of LANE_WIDTH");
  end

  fill_state_t           state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH:0]   remaining;
  logic [DATA_WIDTH-1:0] value;
  logic                  busy;
  logic                  done;
  logic                  clear_pend;

  logic                  a_fire;
  logic [NL-1:0]         we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] a_rdata1;
  logic [DATA_WIDTH-1:0] b_rdata1;
  logic                  rvalid1;

  assign a_fire        = bus.a_req && !busy;
  assign bus.a_ready   = !busy;
  assign bus.fill_busy = busy;
  assign bus.fill_done = done;

  // A pending post-reset clear takes precedence over any external fill request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      remaining  <= '0;
      value      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      clear_pend <= (CLEAR_ON_RESET != 0);
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_pend) begin
            clear_pend <= 1'b0;
            state      <= FILL;
            busy       <= 1'b1;
            ptr        <= '0;
            remaining  <= DEPTH;
            value      <= '0;
          end else if (bus.fill_start) begin
            if (bus.fill_len == '0) begin
              done <= 1'b1;
            end else begin
              state     <= FILL;
              busy      <= 1'b1;
              ptr       <= bus.fill_base;
              remaining <= bus.fill_len;
              value     <= bus.fill_value;
            end
          end
        end
        FILL: begin
          ptr       <= ptr + ADDR_WIDTH'(1);
          remaining <= remaining - (ADDR_WIDTH+1)'(1);
          if (remaining == (ADDR_WIDTH+1)'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reset suppresses the write port so an aborted fill leaves no write on that edge.
  always_comb begin
    we    = '0;
    waddr = bus.a_addr;
    wdata = bus.a_wdata;
    if (!rst) begin
      if (busy) begin
        we    = '1;
        waddr = ptr;
        wdata = value;
      end else if (a_fire) begin
        we = bus.a_we;
      end
    end
  end

  vga_mem_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANE_WIDTH (LANE_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NL         (NL)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .a_en    (a_fire),
    .a_addr  (bus.a_addr),
    .b_addr  (bus.b_addr),
    .a_rdata (a_rdata1),
    .b_rdata (b_rdata1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid1 <= 1'b0;
    end else begin
      rvalid1 <= a_fire;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] a_rdata2;
    logic [DATA_WIDTH-1:0] b_rdata2;
    logic                  rvalid2;

    always_ff @(posedge clk) begin
      if (rst) begin
        a_rdata2 <= '0;
        b_rdata2 <= '0;
        rvalid2  <= 1'b0;
      end else begin
        a_rdata2 <= a_rdata1;
        b_rdata2 <= b_rdata1;
        rvalid2  <= rvalid1;
      end
    end

    assign bus.a_rdata  = a_rdata2;
    assign bus.b_rdata  = b_rdata2;
    assign bus.a_rvalid = rvalid2;
  end else begin : g_lat1
    assign bus.a_rdata  = a_rdata1;
    assign bus.b_rdata  = b_rdata1;
    assign bus.a_rvalid = rvalid1;
  end

endmodule
